// File: rtl/piso_tx_pkg.sv
// Shared constants for the shift-register family: FSM encodings and sizing helpers.
package piso_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sr_state_t;

    localparam int SR_LOOPBACK_DEPTH = 4;

    // Counter width for a 0..w-1 count; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Mod-WIDTH bit counter. It clears on a new frame and advances while enabled.
// It holds at the terminal count until the next clear.
module bit_counter
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;
    logic          w_tc;

    assign w_tc = (r_count == LAST);
    assign o_tc = w_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_tc) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. A WIDTH-bit word is sent one bit per clk.
// A load accepted in the final bit cycle chains the next frame with no gap.
//   state    | meaning
//   ST_IDLE  | no frame; dout=0, load_ready=1
//   ST_SHIFT | frame bit on dout; load_ready only on the last bit
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    sr_state_t        r_state;
    sr_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic             w_tc;
    logic             w_ready;
    logic             w_accept;
    logic             w_bit;
    logic             w_shifting;

    assign w_shifting = (r_state == ST_SHIFT);
    // Gated by rst so the block never advertises readiness while held in reset.
    assign w_ready    = !rst && (!w_shifting || w_tc);
    assign w_accept   = load_valid && w_ready;
    assign w_bit      = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];

    assign load_ready = w_ready;
    assign dout       = w_shifting && w_bit;
    assign dout_valid = w_shifting;
    assign busy       = w_shifting;
    assign done       = w_shifting && w_tc;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_en  (w_shifting),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tc) begin
                    w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= din;
        end else if (w_shifting) begin
            if (MSB_FIRST != 0) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end else begin
                r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB-first and LSB-first instances, plus a 4-stage loopback register.
module tb_piso_tx;
    import piso_tx_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] din_m, din_l;
    logic       lv_m, lv_l;
    logic       lr_m, lr_l;
    logic       dout_m, dout_l;
    logic       dv_m, dv_l;
    logic       busy_m, busy_l;
    logic       done_m, done_l;
    logic [SR_LOOPBACK_DEPTH-1:0] r_lb;

    int total = 0;
    int bad   = 0;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .din(din_m), .load_valid(lv_m), .load_ready(lr_m),
        .dout(dout_m), .dout_valid(dv_m), .busy(busy_m), .done(done_m)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .din(din_l), .load_valid(lv_l), .load_ready(lr_l),
        .dout(dout_l), .dout_valid(dv_l), .busy(busy_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the team's 4-stage serial shift register, fed by the MSB-first dout.
    always @(posedge clk or posedge rst) begin
        if (rst) r_lb <= '0;
        else     r_lb <= {r_lb[SR_LOOPBACK_DEPTH-2:0], dout_m};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Observed vectors below are {dout, dout_valid, busy, done, load_ready}.
    task automatic test_reset;
        logic [4:0] e;
        rst = 1'b1; din_m = 4'b1111; lv_m = 1'b1; din_l = 4'b0; lv_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_hold_msb got=%b exp=00000", {dout_m, dv_m, busy_m, done_m, lr_m});
        end
        total++;
        if ({dout_l, dv_l, busy_l, done_l, lr_l} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_hold_lsb got=%b exp=00000", {dout_l, dv_l, busy_l, done_l, lr_l});
        end
        #3 rst = 1'b0;
        #1;
        total++;
        if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_release got=%b exp=00001", {dout_m, dv_m, busy_m, done_m, lr_m});
        end
        tick;
        lv_m = 1'b0;
        total++;
        if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b11100) begin
            bad++;
            $display("FAIL first_edge_accept got=%b exp=11100", {dout_m, dv_m, busy_m, done_m, lr_m});
        end
        repeat (4) tick;
        e = 5'b00001;
        total++;
        if ({dout_m, dv_m, busy_m, done_m, lr_m} !== e) begin
            bad++;
            $display("FAIL reset_drain_idle got=%b exp=%b", {dout_m, dv_m, busy_m, done_m, lr_m}, e);
        end
    endtask

    task automatic test_basic;
        logic [3:0] bits;
        logic [4:0] e;
        bits = 4'b1010;
        din_m = bits; lv_m = 1'b1;
        tick;
        lv_m = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            e = {bits[4-c], 1'b1, 1'b1, (c == 4), (c == 4)};
            total++;
            if ({dout_m, dv_m, busy_m, done_m, lr_m} !== e) begin
                bad++;
                $display("FAIL basic_c%0d got=%b exp=%b", c, {dout_m, dv_m, busy_m, done_m, lr_m}, e);
            end
            tick;
        end
        total++;
        if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b00001) begin
            bad++;
            $display("FAIL basic_idle got=%b exp=00001", {dout_m, dv_m, busy_m, done_m, lr_m});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq;
        logic [4:0] e;
        logic       last;
        seq = 8'b1100_0011;
        din_m = 4'b1100; lv_m = 1'b1;
        tick;
        lv_m = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            last = (c == 4) || (c == 8);
            e = {seq[8-c], 1'b1, 1'b1, last, last};
            total++;
            if ({dout_m, dv_m, busy_m, done_m, lr_m} !== e) begin
                bad++;
                $display("FAIL b2b_c%0d got=%b exp=%b", c, {dout_m, dv_m, busy_m, done_m, lr_m}, e);
            end
            if (c == 4) begin
                din_m = 4'b0011; lv_m = 1'b1;
            end
            tick;
            lv_m = 1'b0;
        end
        total++;
        if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b00001) begin
            bad++;
            $display("FAIL b2b_idle got=%b exp=00001", {dout_m, dv_m, busy_m, done_m, lr_m});
        end
    endtask

    task automatic test_lsb_first;
        logic [3:0] order;
        logic [4:0] e;
        order = 4'b1000;
        din_l = 4'b0001; lv_l = 1'b1;
        tick;
        lv_l = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            e = {order[4-c], 1'b1, 1'b1, (c == 4), (c == 4)};
            total++;
            if ({dout_l, dv_l, busy_l, done_l, lr_l} !== e) begin
                bad++;
                $display("FAIL lsb_c%0d got=%b exp=%b", c, {dout_l, dv_l, busy_l, done_l, lr_l}, e);
            end
            tick;
        end
        total++;
        if ({dout_l, dv_l, busy_l, done_l, lr_l} !== 5'b00001) begin
            bad++;
            $display("FAIL lsb_idle got=%b exp=00001", {dout_l, dv_l, busy_l, done_l, lr_l});
        end
    endtask

    task automatic test_ignore;
        logic [4:0] e;
        din_m = 4'b0000; lv_m = 1'b1;
        tick;
        for (int c = 1; c <= 4; c++) begin
            if (c <= 3) begin
                din_m = 4'b1111; lv_m = 1'b1;
            end else begin
                lv_m = 1'b0;
            end
            e = {1'b0, 1'b1, 1'b1, (c == 4), (c == 4)};
            total++;
            if ({dout_m, dv_m, busy_m, done_m, lr_m} !== e) begin
                bad++;
                $display("FAIL ignore_c%0d got=%b exp=%b", c, {dout_m, dv_m, busy_m, done_m, lr_m}, e);
            end
            tick;
        end
        tick;
        total++;
        if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b00001) begin
            bad++;
            $display("FAIL ignore_idle got=%b exp=00001", {dout_m, dv_m, busy_m, done_m, lr_m});
        end
    endtask

    task automatic test_reset_mid_frame;
        din_m = 4'b1111; lv_m = 1'b1;
        tick;
        lv_m = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            total++;
            if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b11100) begin
                bad++;
                $display("FAIL midrst_c%0d got=%b exp=11100", c, {dout_m, dv_m, busy_m, done_m, lr_m});
            end
            if (c == 1) tick;
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b00000) begin
            bad++;
            $display("FAIL midrst_abort got=%b exp=00000", {dout_m, dv_m, busy_m, done_m, lr_m});
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b00001) begin
            bad++;
            $display("FAIL midrst_release got=%b exp=00001", {dout_m, dv_m, busy_m, done_m, lr_m});
        end
        for (int c = 1; c <= 4; c++) begin
            tick;
            total++;
            if ({dout_m, dv_m, busy_m, done_m, lr_m} !== 5'b00001) begin
                bad++;
                $display("FAIL midrst_after_c%0d got=%b exp=00001", c, {dout_m, dv_m, busy_m, done_m, lr_m});
            end
        end
    endtask

    task automatic test_loopback;
        logic [3:0] bits;
        logic       e;
        bits = 4'b1100;
        din_m = bits; lv_m = 1'b1;
        tick;
        lv_m = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            e = (c >= 5) ? bits[8-c] : 1'b0;
            total++;
            if (r_lb[SR_LOOPBACK_DEPTH-1] !== e) begin
                bad++;
                $display("FAIL loopback_c%0d got=%b exp=%b", c, r_lb[SR_LOOPBACK_DEPTH-1], e);
            end
            tick;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_lsb_first;
        test_ignore;
        test_reset_mid_frame;
        test_loopback;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, number of data bits per frame (SHALL be >= 2).
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 Ports SHALL be exactly as follows, clock and reset first:
  clk  input  1  rising-edge system clock.
  rst  input  1  asynchronous, active-high reset.
  din  input  WIDTH  parallel word to serialize.
  load_valid  input  1  din holds a word to send.
  load_ready  output  1  block accepts din this cycle.
  dout  output  1  serial data bit.
  dout_valid  output  1  dout carries a frame bit.
  busy  output  1  a frame is in progress.
  done  output  1  one-cycle pulse marking the last bit of a frame.

Function
REQ-004 The block SHALL have two states: IDLE and SHIFT.
REQ-005 A load is accepted at a rising clk edge where load_valid=1 and load_ready=1; din SHALL be captured into an internal WIDTH-bit shift register at that edge.
REQ-006 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only during the final bit cycle (bit count = WIDTH-1); otherwise 0.
REQ-007 On accept from IDLE: transition to SHIFT; in the next cycle dout = first bit, dout_valid=1, busy=1.
REQ-008 In SHIFT: each bit SHALL be held on dout for exactly one clk cycle; a bit counter 0..WIDTH-1 SHALL advance every cycle; frame length is exactly WIDTH cycles.
REQ-009 Latency: accept edge to first bit on dout = 1 cycle; accept edge to last bit = WIDTH cycles.
REQ-010 done SHALL be 1 only in the cycle where the last bit (count = WIDTH-1) is on dout.
REQ-011 Back-to-back: if a load is accepted in the final bit cycle, the next frame's first bit SHALL appear in the very next cycle with no gap; state stays SHIFT, and busy and dout_valid stay 1.
REQ-012 If there is no accept in the final bit cycle: return to IDLE; dout_valid=0, busy=0, and dout=0 in the following cycle.
REQ-013 load_valid while load_ready=0 SHALL be ignored; din changes mid-frame SHALL NOT affect the bits being sent.
REQ-014 Bit order SHALL follow MSB_FIRST; the counter wraps from WIDTH-1 to 0 only on a new accept.
REQ-015 In IDLE, dout SHALL be 0.

Reset
REQ-016 While rst=1, regardless of clk: state=IDLE, shift register=0, counter=0, dout=0, dout_valid=0, busy=0, done=0, load_ready=0.
REQ-017 Reset asserted mid-frame SHALL abort the frame immediately; no remaining bits are sent after release.
REQ-018 After rst deasserts, load_ready SHALL be 1, and the first accept is possible at the first rising clk edge.

Structure
REQ-019 State encodings (IDLE=0, SHIFT=1) SHALL reside in a shared include/package file with the other shift-register blocks' constants.
REQ-020 The counter width SHALL be derived from WIDTH (clog2), not hard-coded.
REQ-021 A single sub-module, bit_counter (mod-WIDTH counter with terminal-count output), is natural; the FSM and shift register stay in piso_tx.

Verification
REQ-022 WIDTH=4, MSB_FIRST=1, load 4'b1010 from IDLE -> dout 1,0,1,0 in cycles 1-4 after accept, dout_valid=1 for those 4 cycles, done=1 only in cycle 4, then IDLE.
REQ-023 Back-to-back: 4'b1100 then 4'b0011 (second accepted in the final bit cycle) -> 8 contiguous bits 1,1,0,0,0,0,1,1, busy never drops, done pulses in cycles 4 and 8.
REQ-024 MSB_FIRST=0, load 4'b0001 -> dout 1,0,0,0.
REQ-025 load_valid=1 with din=4'b1111 during bit cycles 1-3 of a 4'b0000 frame -> ignored; dout stays 0,0,0,0 and load_ready=0 in those cycles.
REQ-026 rst pulsed mid-frame, between clk edges, after bit 2 -> outputs zero immediately, no further dout_valid, and load_ready=1 after release.
REQ-027 Loopback: piso_tx dout drives the team's 4-stage serial shift register -> that register's output replays each transmitted bit exactly 4 cycles later.
